// File: rtl/mux_arbiter4_if.sv
// Bus between the four requesting stages and the shared-mux arbiter.
// The requesters drive level requests. The arbiter returns the one-hot
// grant, the 2-bit mux select and a busy flag.
interface mux_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] pos;
  logic       busy;

  // Requesting stages
  modport master (output req, input gnt, input pos, input busy);

  // Arbiter
  modport slave  (input req, output gnt, output pos, output busy);
endinterface

// File: rtl/mux_arbiter4.sv
// Round-robin arbiter for a shared 32-bit 4:1 datapath mux.
// Produces a registered mux select (pos), a one-hot grant and busy.
// A starvation guard hands the mux to another requester once the
// current owner has held it MAX_HOLD cycles while others were waiting.
module mux_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic          clk,
  input  logic          rst,
  mux_arbiter4_if.slave bus
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam bit               PREEMPT_EN = (MAX_HOLD != 0);

  state_t           r_state;
  logic [3:0]       r_gnt;
  logic [1:0]       r_pos;
  logic             r_busy;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [1:0]       r_last;

  logic [3:0]       w_others;
  logic             w_pick_vld;
  logic [1:0]       w_pick_idx;
  logic             w_hold_expired;

  // Round-robin scan: last+1, last+2, last+3, then last itself.
  // The loop walks from farthest to nearest, so the nearest hit is written last and wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] req_v, input logic [1:0] last_v);
    logic [1:0] cand;
    logic [2:0] res;
    res = {1'b0, last_v};
    for (int k = 4; k >= 1; k--) begin
      cand = last_v + 2'(k);
      if (req_v[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Index to one-hot grant vector
  function automatic logic [3:0] idx2onehot(input logic [1:0] idx);
    logic [3:0] oh;
    case (idx)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  // Arbitration decode from current requests and the round-robin pointer
  always_comb begin
    w_others   = bus.req & ~r_gnt;
    {w_pick_vld, w_pick_idx} = rr_pick(bus.req, r_last);
    if (PREEMPT_EN && (r_hold_cnt >= MAX_HOLD_C) && (w_others != 4'b0000)) begin
      w_hold_expired = 1'b1;
    end else begin
      w_hold_expired = 1'b0;
    end
  end

  // Arbiter state machine with registered grant, select and busy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gnt      <= 4'b0000;
      r_pos      <= 2'b00;
      r_busy     <= 1'b0;
      r_hold_cnt <= CNT_ZERO;
      r_last     <= 2'd3;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_state    <= S_GRANT;
            r_gnt      <= idx2onehot(w_pick_idx);
            r_pos      <= w_pick_idx;
            r_busy     <= 1'b1;
            r_last     <= w_pick_idx;
            r_hold_cnt <= CNT_ONE;
          end else begin
            r_state    <= S_IDLE;
          end
        end
        S_GRANT: begin
          if (!bus.req[r_pos]) begin
            if (w_others != 4'b0000) begin
              // Owner released while others wait: hand over on this edge, no idle bubble
              r_gnt      <= idx2onehot(w_pick_idx);
              r_pos      <= w_pick_idx;
              r_last     <= w_pick_idx;
              r_hold_cnt <= CNT_ONE;
            end else begin
              // Nobody left: go idle and keep the select where it was
              r_state    <= S_IDLE;
              r_gnt      <= 4'b0000;
              r_busy     <= 1'b0;
              r_hold_cnt <= CNT_ZERO;
            end
          end else if (w_hold_expired) begin
            // Starvation guard. last equals the owner, so the pick never returns the owner.
            r_gnt      <= idx2onehot(w_pick_idx);
            r_pos      <= w_pick_idx;
            r_last     <= w_pick_idx;
            r_hold_cnt <= CNT_ONE;
          end else if (PREEMPT_EN && (r_hold_cnt >= MAX_HOLD_C)) begin
            r_hold_cnt <= MAX_HOLD_C;
          end else if (r_hold_cnt != {CNT_W{1'b1}}) begin
            r_hold_cnt <= r_hold_cnt + CNT_ONE;
          end else begin
            r_hold_cnt <= r_hold_cnt;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_gnt      <= 4'b0000;
          r_busy     <= 1'b0;
          r_hold_cnt <= CNT_ZERO;
        end
      endcase
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.pos  = r_pos;
  assign bus.busy = r_busy;

endmodule
